// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Data has priority; a saturating streak counter forces a fetch after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  input  logic              d_ext,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              m_valid,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [1:0]        m_size,
  output logic              m_ext,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_next;
  logic [3:0] streak, streak_next;
  logic       flush_pend;
  logic       grant_d, grant_i, done;
  logic       fetch_killed;

  // Stalls depend only on request and ack, never on m_ready.
  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

  // A flush arriving on the completion edge itself also kills the fetch.
  assign fetch_killed = flush_pend | if_flush;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_next  = state;
    streak_next = streak;
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (streak < LIMIT || !if_req)) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (if_req && !if_flush) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end
        if (!if_req || grant_i) begin
          streak_next = '0;
        end else if (grant_d && streak < LIMIT) begin
          streak_next = streak + 4'd1;
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state      <= IDLE;
      streak     <= '0;
      flush_pend <= 1'b0;
    end else begin
      state  <= state_next;
      streak <= streak_next;
      if (done) begin
        flush_pend <= 1'b0;
      end else if (state == BUSY_I && if_flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid  <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_size   <= 2'b00;
      m_ext    <= 1'b0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      if (grant_d) begin
        m_valid <= 1'b1;
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_size  <= d_size;
        m_ext   <= d_ext;
      end else if (grant_i) begin
        m_valid <= 1'b1;
        m_we    <= 1'b0;
        m_addr  <= if_addr;
        m_wdata <= '0;
        m_size  <= 2'b11;
        m_ext   <= 1'b0;
      end
      if (done) begin
        m_valid <= 1'b0;
        m_we    <= 1'b0;
        if (state == BUSY_D) begin
          d_ack   <= 1'b1;
          d_rdata <= m_rdata;
        end else if (!fetch_killed) begin
          if_ack   <= 1'b1;
          if_rdata <= m_rdata;
        end
      end
    end
  end

endmodule
